instr_fetch_stage: RTL
======================

# instr_fetch_stage

Fetch stage directly downstream of the PC block. Issues synchronous instruction-memory reads at the current PC, absorbs the one-cycle memory latency, and presents the instruction together with its own PC (`PC_delayed`) to decode. It owns the IF/ID pipeline register, a one-entry hold buffer for decode stalls, branch-redirect flushing, and the stall request back to the PC register.

## Interface
- `RESET_PC`, 32'h00000014: must match the PC block's reset value. Used only for the `PC_delayed` reset value.
- `NOP_INSTR`, 32'h00000013: bubble instruction (`addi x0,x0,0`).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `PC`  in  32  current PC from the PC block.
- `PCSrc`  in  1  redirect; same signal that selects `PCTarget` in the PC block.
- `decode_stall`  in  1  decode/hazard unit requests that IF/ID hold.
- `imem_en`  out  1  read enable.
- `imem_addr`  out  32  read address, equal to `PC`.
- `imem_rdata`  in  32  read data, valid exactly one cycle after an enabled read.
- `PCstall`  out  1  freezes the PC register.
- `Instr`  out  32  IF/ID instruction.
- `PC_delayed`  out  32  PC of `Instr`.
- `PCPlus4_D`  out  32  `PC_delayed + 4`, mod 2^32.
- `instr_valid`  out  1  `Instr` is a real instruction, not a bubble.
- `fetch_count`  out  32  number of valid instructions loaded into IF/ID, wraps at 2^32.

## Operation
- Combinational outputs:
  - `imem_addr = PC`.
  - `PCstall = decode_stall & ~PCSrc`. A redirect always lets the PC update.
  - `imem_en = ~PCstall & ~rst`.
- Request tracking:
  - On each edge, `pc_q <= PC` and `live <= imem_en & ~PCSrc`.
  - A request issued in the same cycle as `PCSrc` is killed. Its returning data is discarded.
- Hold buffer (`hold_instr`, `hold_pc`, `hold_valid`):
  - Written when `live=1` and `decode_stall=1` and `PCSrc=0`.
  - Cleared when IF/ID consumes it or on `PCSrc`.
- Response source, derived from `live`/`hold_valid`. Exactly one state at a time:
  - EMPTY: `live=0`, `hold_valid=0`. The source is a bubble.
  - LIVE: `live=1`. The source is `imem_rdata`/`pc_q`.
  - HELD: `hold_valid=1`. The source is `hold_instr`/`hold_pc`.
  - LIVE and HELD together is illegal. While `hold_valid=1`, `PCstall` is high, so no request is issued. Assert this in the bench.
- IF/ID update, in priority order:
  1. `PCSrc=1`: load `Instr=NOP_INSTR`, `instr_valid=0`, and clear `hold_valid`. This applies even if `decode_stall=1`.
  2. `decode_stall=1`: hold IF/ID. A LIVE response moves into the hold buffer.
  3. Otherwise, load from the source. HELD takes precedence over LIVE. EMPTY loads `NOP_INSTR` with `instr_valid=0`, and `PC_delayed` keeps its previous value.
- `fetch_count` increments by 1 on each edge that loads IF/ID with `instr_valid=1`.

## Timing
- Reset values:
  - `Instr=NOP_INSTR`, `instr_valid=0`, `PC_delayed=RESET_PC`, `PCPlus4_D=RESET_PC+4`.
  - `fetch_count=0`, `live=0`, `hold_valid=0`, `pc_q=RESET_PC`.
- First request is issued in the first cycle after `rst` falls. Its instruction appears on `Instr` two edges after that request edge... counted precisely: request in cycle 0, data in cycle 1, visible on `Instr` in cycle 2.
- Steady-state throughput: 1 instruction per cycle. Fetch-to-decode latency: 2 cycles (request, then IF/ID).
- Redirect:
  - `PCSrc` in cycle t kills the cycle-t request and inserts a bubble into IF/ID at edge t.
  - The target is requested in cycle t+1 and is valid in IF/ID in cycle t+3.
  - Net cost: 2 bubbles.
- Decode stall:
  - Starting in cycle t, the response arriving in t is held.
  - On release in cycle r: the held instruction loads at edge r, a new request is issued in r, and there is no bubble.
- Simultaneous `PCSrc` and `decode_stall`: `PCSrc` wins, IF/ID is flushed, and the PC advances.
- `rst` asserted mid-operation: all state returns to reset values immediately (asynchronous). In-flight memory data is ignored.

## Test plan
- Reset then free-run: imem returns `addr^32'hA5A50000`. The first valid `Instr` is `32'hA5A50014` with `PC_delayed=0x14`, followed by 0x18 and 0x1C on consecutive cycles. `fetch_count` increments every cycle.
- Decode stall for 3 cycles while PC=0x20 is in flight: `PCstall=1` for exactly 3 cycles, `Instr` is frozen, 0x20 is loaded on release, and 0x24 is loaded on the next edge. No duplicates, no bubbles.
- `PCSrc=1` with target 0x100 while fetching 0x2C: exactly 2 cycles of `instr_valid=0`, then `PC_delayed=0x100`. The 0x2C data never appears.
- `PCSrc` and `decode_stall` asserted in the same cycle with `hold_valid=1`: the hold buffer is discarded, IF/ID becomes `NOP_INSTR`, and `PCstall=0`.
- `rst` pulsed mid-stream with `hold_valid=1`: outputs return to reset values within the same cycle, and fetch restarts at 0x14.
- `fetch_count` preloaded near wrap (force 32'hFFFFFFFF): the next valid load gives 0.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: issues imem reads at PC, absorbs the read latency,
// and owns the IF/ID register, a one-entry stall hold buffer and redirect flush.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h00000014,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        PCSrc,
    input  logic        decode_stall,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        PCstall,
    output logic [31:0] Instr,
    output logic [31:0] PC_delayed,
    output logic [31:0] PCPlus4_D,
    output logic        instr_valid,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        SRC_EMPTY,
        SRC_LIVE,
        SRC_HELD
    } src_e;

    logic        live;
    logic [31:0] pc_q;
    logic        hold_valid;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;

    src_e        src;

    logic        ifid_load;
    logic        ld_valid;
    logic [31:0] ld_instr;
    logic [31:0] ld_pc;
    logic        hold_wr;
    logic        hold_clr;

    assign imem_addr = PC;
    assign PCstall   = decode_stall & ~PCSrc;
    assign imem_en   = ~PCstall & ~rst;
    assign PCPlus4_D = PC_delayed + 32'd4;

    // A held entry can only exist while no request is in flight.
    always_comb begin
        src = SRC_EMPTY;
        unique case (1'b1)
            hold_valid: src = SRC_HELD;
            live:       src = SRC_LIVE;
            default:    src = SRC_EMPTY;
        endcase
    end

    always_comb begin
        ifid_load = 1'b0;
        ld_valid  = 1'b0;
        ld_instr  = NOP_INSTR;
        ld_pc     = PC_delayed;
        hold_wr   = 1'b0;
        hold_clr  = 1'b0;
        if (PCSrc) begin
            ifid_load = 1'b1;
            hold_clr  = 1'b1;
        end else if (decode_stall) begin
            hold_wr = (src == SRC_LIVE);
        end else begin
            ifid_load = 1'b1;
            unique case (src)
                SRC_HELD: begin
                    ld_valid = 1'b1;
                    ld_instr = hold_instr;
                    ld_pc    = hold_pc;
                    hold_clr = 1'b1;
                end
                SRC_LIVE: begin
                    ld_valid = 1'b1;
                    ld_instr = imem_rdata;
                    ld_pc    = pc_q;
                end
                default: begin
                    ld_valid = 1'b0;
                end
            endcase
        end
    end

    // Request tracking: a request issued alongside a redirect is dead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
            live <= 1'b0;
        end else begin
            pc_q <= PC;
            live <= imem_en & ~PCSrc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_instr <= NOP_INSTR;
            hold_pc    <= RESET_PC;
        end else if (hold_wr) begin
            hold_valid <= 1'b1;
            hold_instr <= imem_rdata;
            hold_pc    <= pc_q;
        end else if (hold_clr) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            PC_delayed  <= RESET_PC;
            fetch_count <= 32'd0;
        end else if (ifid_load) begin
            Instr       <= ld_instr;
            instr_valid <= ld_valid;
            PC_delayed  <= ld_pc;
            if (ld_valid) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule
